// File: rtl/gpio_edge_irq_ctrl.sv
// GPIO event controller: synchronises and debounces NCH inputs, latches enabled
// rising/falling edges into W1C status flags and raises a level interrupt.
module gpio_edge_irq_ctrl #(
    parameter int NCH        = 8,
    parameter int DEBOUNCE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  iomem_valid,
    output logic                  iomem_ready,
    input  logic [3:0]            iomem_wstrb,
    input  logic [31:0]           iomem_addr,
    input  logic [31:0]           iomem_wdata,
    output logic [31:0]           iomem_rdata,
    input  logic [NCH-1:0]        gpio_in,
    output logic                  irq
);

    localparam logic [2:0] A_RISE_EN  = 3'd0;
    localparam logic [2:0] A_FALL_EN  = 3'd1;
    localparam logic [2:0] A_STATUS   = 3'd2;
    localparam logic [2:0] A_DEBOUNCE = 3'd3;
    localparam logic [2:0] A_INPUT    = 3'd4;

    logic [NCH-1:0]        s1, s2, stable, stable_d;
    logic [NCH-1:0]        rise_en, fall_en, status;
    logic [DEBOUNCE_W-1:0] debounce;
    logic [DEBOUNCE_W-1:0] cnt [NCH];

    logic [2:0]   sel;
    logic         access, we;
    logic [31:0]  wmask, rd_mux, rise_wr, fall_wr, deb_wr;
    logic [NCH-1:0] rise, fall, evt, w1c_mask;
    logic         unused_bits;

    // Handshake: a request is taken on any edge where iomem_valid is high and
    // iomem_ready is low; iomem_ready then pulses for exactly one cycle with
    // iomem_rdata valid, and the master holds its request until that pulse.
    assign sel    = iomem_addr[4:2];
    assign access = iomem_valid && !iomem_ready;
    assign we     = access && (iomem_wstrb != 4'b0000);
    assign wmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

    always_comb begin
        rise_wr = (32'(rise_en)  & ~wmask) | (iomem_wdata & wmask);
        fall_wr = (32'(fall_en)  & ~wmask) | (iomem_wdata & wmask);
        deb_wr  = (32'(debounce) & ~wmask) | (iomem_wdata & wmask);
    end

    always_comb begin
        w1c_mask = '0;
        if (we && sel == A_STATUS)
            w1c_mask = iomem_wdata[NCH-1:0] & wmask[NCH-1:0];
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign evt  = (rise & rise_en) | (fall & fall_en);
    assign irq  = |status;

    always_comb begin
        rd_mux = 32'h0;
        case (sel)
            A_RISE_EN:  rd_mux = 32'(rise_en);
            A_FALL_EN:  rd_mux = 32'(fall_en);
            A_STATUS:   rd_mux = 32'(status);
            A_DEBOUNCE: rd_mux = 32'(debounce);
            A_INPUT:    rd_mux = 32'(stable);
            default:    rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            s1       <= gpio_in;
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= debounce) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    // A new event in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status <= '0;
        end else begin
            status <= (status & ~w1c_mask) | evt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_en     <= '0;
            fall_en     <= '0;
            debounce    <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
        end else begin
            iomem_ready <= access;
            if (access)
                iomem_rdata <= rd_mux;
            if (we) begin
                case (sel)
                    A_RISE_EN:  rise_en  <= rise_wr[NCH-1:0];
                    A_FALL_EN:  fall_en  <= fall_wr[NCH-1:0];
                    A_DEBOUNCE: debounce <= deb_wr[DEBOUNCE_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    assign unused_bits = ^{iomem_addr, rise_wr, fall_wr, deb_wr};

endmodule

// File: tb/tb_gpio_edge_irq_ctrl.sv
// Bench for gpio_edge_irq_ctrl: directed scenarios plus random GPIO/bus traffic,
// with read data predicted by a history-window reference model.
module tb_gpio_edge_irq_ctrl;

    localparam int NCH = 8;
    localparam int DW  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic           iomem_valid;
    logic           iomem_ready;
    logic [3:0]     iomem_wstrb;
    logic [31:0]    iomem_addr;
    logic [31:0]    iomem_wdata;
    logic [31:0]    iomem_rdata;
    logic [NCH-1:0] gpio_in;
    logic           irq;

    gpio_edge_irq_ctrl #(.NCH(NCH), .DEBOUNCE_W(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .irq         (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A channel's debounced level flips once the synchronised input (two samples
    // old) has disagreed with it for DEBOUNCE+1 consecutive samples; an enabled
    // flip becomes a STATUS bit one cycle later.
    logic [NCH-1:0] m_stable = '0, m_stable_d = '0;
    logic [NCH-1:0] m_rise = '0, m_fall = '0, m_status = '0;
    logic [31:0]    m_deb = '0;
    logic           m_ready = 1'b0;
    logic [NCH-1:0] hist[$];

    logic           acc_m, wr_m, ok_m;
    logic [2:0]     a_m;
    logic [31:0]    bm_m, nv_m;
    logic [NCH-1:0] evt_m, flip_m, w1c_m;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_rise);
            3'd1:    return 32'(m_fall);
            3'd2:    return 32'(m_status);
            3'd3:    return m_deb;
            3'd4:    return 32'(m_stable);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_stable = '0; m_stable_d = '0; m_rise = '0; m_fall = '0;
            m_status = '0; m_deb = '0; m_ready = 1'b0;
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            exp_q.delete();
        end else begin
            acc_m = iomem_valid && !m_ready;
            wr_m  = acc_m && (iomem_wstrb != 4'b0);
            a_m   = iomem_addr[4:2];
            bm_m  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
            evt_m = (m_stable & ~m_stable_d & m_rise) | (~m_stable & m_stable_d & m_fall);
            hist.push_front(gpio_in);
            if (hist.size() > 300) void'(hist.pop_back());
            flip_m = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                ok_m = 1'b1;
                for (int j = 0; j <= int'(m_deb); j++) begin
                    if (2 + j >= hist.size() || hist[2 + j][ch] == m_stable[ch]) begin
                        ok_m = 1'b0;
                        break;
                    end
                end
                flip_m[ch] = ok_m;
            end
            w1c_m = (wr_m && a_m == 3'd2) ? (iomem_wdata[NCH-1:0] & bm_m[NCH-1:0]) : '0;
            nv_m  = (m_read(a_m) & ~bm_m) | (iomem_wdata & bm_m);
            if (acc_m) exp_q.push_back(m_read(a_m));
            m_stable_d = m_stable;
            m_stable   = m_stable ^ flip_m;
            m_status   = (m_status & ~w1c_m) | evt_m;
            if (wr_m) begin
                case (a_m)
                    3'd0:    m_rise = nv_m[NCH-1:0];
                    3'd1:    m_fall = nv_m[NCH-1:0];
                    3'd3:    m_deb  = nv_m & 32'h0000_FFFF;
                    default: ;
                endcase
            end
            m_ready = acc_m;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (resetn) begin
            check("ready", 32'(iomem_ready), 32'(m_ready));
            check("irq", 32'(irq), 32'(|m_status));
            if (iomem_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rdata_unexpected: got %h expected no response", iomem_rdata);
                end else begin
                    check("rdata", iomem_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!iomem_ready && t < 8);
        if (!iomem_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_timeout: got no ready expected ready within 8 cycles, addr %h", a);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus(a, 32'h0, 4'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] ra;
        iomem_valid = 1'b0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        iomem_wstrb = 4'h0;
        gpio_in     = 8'hFF;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset / idle: inputs high at release become stable without STATUS.
        idle(3);
        rd(32'h10);
        rd(32'h08);

        // Rise path, DEBOUNCE = 0.
        gpio_in = '0;
        idle(5);
        bus(32'h00, 32'h01, 4'hF);
        bus(32'h0C, 32'h00, 4'hF);
        @(negedge clk) gpio_in[0] = 1'b1;
        idle(6);
        rd(32'h08);
        bus(32'h08, 32'h01, 4'hF);
        rd(32'h08);

        // Both edges on channel 7.
        bus(32'h00, 32'h80, 4'hF);
        bus(32'h04, 32'h80, 4'hF);
        @(negedge clk) gpio_in[7] = 1'b1;
        idle(8);
        rd(32'h08);
        bus(32'h08, 32'h80, 4'h1);
        idle(8);
        gpio_in[7] = 1'b0;
        idle(6);
        rd(32'h08);
        bus(32'h08, 32'hFF, 4'hF);

        // Debounce = 4: a 4-cycle glitch is rejected, a 5-cycle pulse is not.
        bus(32'h0C, 32'h04, 4'hF);
        bus(32'h00, 32'h02, 4'hF);
        @(negedge clk) gpio_in[1] = 1'b1;
        idle(4);
        gpio_in[1] = 1'b0;
        idle(10);
        rd(32'h08);
        gpio_in[1] = 1'b1;
        idle(5);
        gpio_in[1] = 1'b0;
        idle(12);
        rd(32'h08);
        bus(32'h08, 32'hFF, 4'hF);

        // Set/clear collision on bit 0: the fall event lands on the W1C edge.
        bus(32'h0C, 32'h00, 4'hF);
        bus(32'h00, 32'h01, 4'hF);
        bus(32'h04, 32'h01, 4'hF);
        bus(32'h08, 32'hFF, 4'hF);
        @(negedge clk) gpio_in[0] = 1'b0;
        idle(6);
        bus(32'h08, 32'hFF, 4'hF);
        @(negedge clk) gpio_in[0] = 1'b1;
        idle(6);
        @(negedge clk) gpio_in[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus(32'h08, 32'h01, 4'h1);
        rd(32'h08);

        // Bus protocol: byte-strobed DEBOUNCE write and unmapped read.
        bus(32'h0C, 32'hFFFF, 4'h1);
        rd(32'h0C);
        rd(32'h1C);
        bus(32'h0C, 32'h00, 4'hF);

        // Reset right after an access is taken: ready must drop at once.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h00;
        iomem_wdata = 32'hFF;
        iomem_wstrb = 4'hF;
        @(posedge clk);
        #1 resetn = 1'b0;
        #1 check("ready_in_reset", 32'(iomem_ready), 32'h0);
        check("irq_in_reset", 32'(irq), 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        idle(2);
        resetn = 1'b1;
        idle(4);
        rd(32'h00);
        rd(32'h10);

        // Random traffic.
        repeat (400) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    @(negedge clk) gpio_in = NCH'($urandom);
                    idle($urandom_range(0, 8));
                end
                2: begin
                    ra = 3'($urandom_range(0, 7));
                    bus({27'h0, ra, 2'b00}, $urandom, (ra >= 3'd4) ? 4'($urandom) : 4'h0);
                end
                3: bus({29'h0, 1'($urandom_range(0, 1)), 2'b00}, $urandom, 4'($urandom));
                4: bus(32'h08, $urandom, 4'($urandom));
                default: bus(32'h0C, 32'($urandom_range(0, 6)), 4'hF);
            endcase
        end

        idle(10);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_edge_irq_ctrl.md
# gpio_edge_irq_ctrl

Memory-mapped GPIO event controller for the PicoSoC peripheral bus. Synchronises and debounces `NCH` external inputs, detects rising and/or falling edges per channel under software control, latches them into write-1-to-clear status flags, and raises a level interrupt to the CPU. It is the configuration and sequencing layer around the positive/negative edge detection used elsewhere in the SoC.

## Interface
- `NCH`, 8, number of input channels (1..16)
- `DEBOUNCE_W`, 16, width of per-channel debounce counters and DEBOUNCE register

- `clk`  in  1  system clock
- `resetn`  in  1  reset, asynchronous, active-low
- `iomem_valid`  in  1  bus request, already qualified by the SoC address decoder
- `iomem_ready`  out  1  bus acknowledge, one-cycle pulse
- `iomem_wstrb`  in  4  byte write strobes; all zero means read
- `iomem_addr`  in  32  byte address; only `[4:2]` decoded
- `iomem_wdata`  in  32  write data
- `iomem_rdata`  out  32  read data, registered, valid while `iomem_ready`=1
- `gpio_in`  in  NCH  asynchronous external inputs
- `irq`  out  1  level interrupt, high while any STATUS bit is set

## Operation
- Register map (`addr[4:2]`):
  - 0 RISE_EN RW `[NCH-1:0]`
  - 1 FALL_EN RW `[NCH-1:0]`
  - 2 STATUS R/W1C `[NCH-1:0]`
  - 3 DEBOUNCE RW `[DEBOUNCE_W-1:0]`
  - 4 INPUT RO: debounced stable levels
  - 5..7 read 0; writes ignored
- Unimplemented bits read 0. Writes honour `iomem_wstrb` per byte. W1C applies only in strobed bytes.
- Per channel, in order:
  - Two-flop synchroniser `s1 -> s2`.
  - Debouncer with `stable` and `cnt`:
    - if `s2 == stable`: `cnt <= 0`.
    - else if `cnt >= DEBOUNCE`: `stable <= s2`, `cnt <= 0`.
    - else `cnt <= cnt + 1` (saturating; cannot exceed DEBOUNCE in practice).
  - Edge stage: `stable_d <= stable`; `rise = stable & ~stable_d`; `fall = ~stable & stable_d`.
  - `event = (rise & RISE_EN) | (fall & FALL_EN)`.
- `STATUS <= (STATUS & ~w1c_mask) | event`. A set in the same cycle as a clear wins (the bit stays 1).
- `irq = |STATUS`. Decoded from registers only; no combinational path from `gpio_in`.
- A DEBOUNCE write takes effect on the next cycle. In-progress counters are not cleared, and comparison uses `>=`.
- Enable changes affect only events generated after the write. They never set or clear STATUS.
- Bus handshake:
  - On an edge with `iomem_valid && !iomem_ready`: `iomem_ready <= 1`, `iomem_rdata` loaded, write applied.
  - Next edge: `iomem_ready <= 0`.
  - Exactly one access per `valid` assertion. The master holds `valid`, `addr`, `wdata` and `wstrb` until ready.

## Timing
- Reset (async assert, sync release): all registers 0 (s1, s2, stable, stable_d, cnt, RISE_EN, FALL_EN, STATUS, DEBOUNCE). Outputs: `iomem_ready`=0, `iomem_rdata`=0, `irq`=0.
- Inputs high at reset release propagate to `stable` as a rise. No STATUS is set because enables reset to 0.
- Input-to-STATUS latency: `gpio_in` change sampled at edge k gives STATUS set at edge k+3+DEBOUNCE; `irq` high in the following cycle.
- Pulses (after sync) shorter than DEBOUNCE+1 cycles are rejected.
- Bus latency: ready one cycle after valid. Back-to-back accesses cost 2 cycles each.
- Reset asserted mid-access: ready drops immediately and no partial write is retained.
- STATUS read in the same cycle as an event returns the pre-event value. The event is visible on the next read.

## Test plan
- Reset/idle: hold `resetn`=0 with `gpio_in`=0xFF, release. Required: ready=0, irq=0, STATUS=0, INPUT=0xFF after 3 cycles.
- Rise path: RISE_EN=0x01, DEBOUNCE=0, toggle `gpio_in[0]` 0->1 at edge k. Required: STATUS=0x01 at k+3, irq=1. Write 0x01 to STATUS. Required: STATUS=0, irq=0.
- Falling/both edges: RISE_EN=FALL_EN=0x80, pulse `gpio_in[7]` high for 20 cycles. Required: STATUS bit 7 set at rise; after clearing, set again at fall.
- Debounce: DEBOUNCE=4, RISE_EN=0x02, glitch `gpio_in[1]` high for 4 cycles. Required: no event. Hold high for 5 cycles. Required: STATUS=0x02 at k+7.
- Set/clear collision: schedule a W1C of bit 0 on the same edge as a new bit-0 event. Required: STATUS[0]=1, irq stays 1.
- Bus protocol: byte-strobed write `wstrb`=0x1 of 0xFFFF to DEBOUNCE. Required: readback 0x00FF, ready pulses exactly one cycle per access. Read address 0x1C returns 0.
